// File: rtl/hack_mem_map_if.sv
// rtl/hack_mem_map_if.sv - Hack data-memory bus plus key-event handshake.
interface hack_mem_map_if;
  logic [15:0] addr_m;
  logic        write_m;
  logic [15:0] out_m;
  logic [15:0] in_m;
  logic        kbd_valid;
  logic [15:0] kbd_code;
  logic        kbd_ready;

  modport master (
    output addr_m, write_m, out_m, kbd_valid, kbd_code,
    input  in_m, kbd_ready
  );

  modport slave (
    input  addr_m, write_m, out_m, kbd_valid, kbd_code,
    output in_m, kbd_ready
  );
endinterface

// File: rtl/hack_mem_map.sv
// rtl/hack_mem_map.sv - Hack data-bus responder: RAM, dual-port screen, key FIFO.
module hack_mem_map #(
  parameter int RAM_AW    = 14,
  parameter int SCR_AW    = 13,
  parameter int KBD_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       xrst,
  hack_mem_map_if.slave              bus,
  input  logic [SCR_AW-1:0]          scr_rd_addr,
  output logic [15:0]                scr_rd_data,
  output logic [$clog2(KBD_DEPTH):0] kbd_count,
  output logic                       err_unmapped
);
  localparam int KW = $clog2(KBD_DEPTH);
  localparam logic [KW:0] DEPTH_C = KBD_DEPTH[KW:0];

  typedef enum logic [1:0] {SEL_NONE, SEL_RAM, SEL_SCR, SEL_KBD} sel_t;

  sel_t        sel_q;
  logic [15:0] ram_mem [0:2**RAM_AW-1];
  logic [15:0] scr_mem [0:2**SCR_AW-1];
  logic [15:0] kbd_mem [0:KBD_DEPTH-1];
  logic [15:0] ram_q, scr_q, scan_q, kbd_q, in_m_c;
  logic        scan_vld;
  logic [KW-1:0] rd_ptr, wr_ptr;
  logic [KW:0]   count;
  logic is_ram, is_scr, is_kbd, full, empty, push, pop;

  always_comb begin
    is_ram = (bus.addr_m[15:14] == 2'b00);
    is_scr = (bus.addr_m[15:13] == 3'b010);
    is_kbd = (bus.addr_m == 16'h6000);
  end

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  // A zero code completes the handshake but is never stored.
  assign push  = bus.kbd_valid && !full && (bus.kbd_code != 16'h0000);
  assign pop   = bus.write_m && is_kbd && !empty;

  assign bus.kbd_ready = !full;
  assign kbd_count     = count;

  // Read-first arrays without reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    ram_q <= ram_mem[bus.addr_m[RAM_AW-1:0]];
    if (bus.write_m && is_ram)
      ram_mem[bus.addr_m[RAM_AW-1:0]] <= bus.out_m;
  end

  always_ff @(posedge clk) begin
    scr_q  <= scr_mem[bus.addr_m[SCR_AW-1:0]];
    scan_q <= scr_mem[scr_rd_addr];
    if (bus.write_m && is_scr)
      scr_mem[bus.addr_m[SCR_AW-1:0]] <= bus.out_m;
  end

  always_ff @(posedge clk) begin
    if (push)
      kbd_mem[wr_ptr] <= bus.kbd_code;
  end

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      sel_q        <= SEL_NONE;
      scan_vld     <= 1'b0;
      kbd_q        <= 16'h0000;
      err_unmapped <= 1'b0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
    end else begin
      scan_vld <= 1'b1;
      // Head is sampled before this edge's pop, so a read+pop returns the old head.
      kbd_q    <= empty ? 16'h0000 : kbd_mem[rd_ptr];
      if (is_ram)
        sel_q <= SEL_RAM;
      else if (is_scr)
        sel_q <= SEL_SCR;
      else if (is_kbd)
        sel_q <= SEL_KBD;
      else begin
        sel_q        <= SEL_NONE;
        err_unmapped <= 1'b1;
      end
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    case (sel_q)
      SEL_RAM: in_m_c = ram_q;
      SEL_SCR: in_m_c = scr_q;
      SEL_KBD: in_m_c = kbd_q;
      default: in_m_c = 16'h0000;
    endcase
  end

  assign bus.in_m    = in_m_c;
  assign scr_rd_data = scan_vld ? scan_q : 16'h0000;
endmodule

// File: tb/tb_hack_mem_map.sv
// tb/tb_hack_mem_map.sv - Vector table plus scoreboard bench for hack_mem_map.
module tb_hack_mem_map;
  localparam int RAM_AW = 14, SCR_AW = 13, KBD_DEPTH = 4;

  logic clk = 1'b0;
  logic xrst = 1'b0;
  logic [SCR_AW-1:0] scr_rd_addr;
  logic [15:0]       scr_rd_data;
  logic [2:0]        kbd_count;
  logic              err_unmapped;

  hack_mem_map_if bus ();

  hack_mem_map #(.RAM_AW(RAM_AW), .SCR_AW(SCR_AW), .KBD_DEPTH(KBD_DEPTH)) dut (
    .clk(clk), .xrst(xrst), .bus(bus.slave),
    .scr_rd_addr(scr_rd_addr), .scr_rd_data(scr_rd_data),
    .kbd_count(kbd_count), .err_unmapped(err_unmapped)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_miss = 0;

  // chk bits: 0 in_m, 1 scr_rd_data, 2 kbd_count, 3 kbd_ready, 4 err_unmapped
  typedef struct {
    string       name;
    logic [15:0] addr;
    logic        we;
    logic [15:0] data;
    logic [12:0] sa;
    logic        kv;
    logic [15:0] kc;
    logic [4:0]  chk;
    logic [15:0] ei, es, ec, er, ee;
  } vec_t;

  typedef struct {
    int          tgt;
    int          kind;
    logic [15:0] exp;
    string       name;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  sb_t  mon_e;

  function automatic vec_t mk(string name, logic [15:0] addr, logic we, logic [15:0] data,
                              logic [12:0] sa, logic kv, logic [15:0] kc, logic [4:0] chk,
                              logic [15:0] ei, logic [15:0] es, logic [15:0] ec,
                              logic [15:0] er, logic [15:0] ee);
    vec_t v;
    v.name = name; v.addr = addr; v.we = we; v.data = data; v.sa = sa;
    v.kv = kv; v.kc = kc; v.chk = chk;
    v.ei = ei; v.es = es; v.ec = ec; v.er = er; v.ee = ee;
    return v;
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] observe(int kind);
    case (kind)
      0: return bus.in_m;
      1: return scr_rd_data;
      2: return {13'h0, kbd_count};
      3: return {15'h0, bus.kbd_ready};
      default: return {15'h0, err_unmapped};
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].tgt <= cyc) begin
      mon_e = sb.pop_front();
      check(mon_e.name, observe(mon_e.kind), mon_e.exp);
    end
  end

  task automatic drive(vec_t v);
    logic [15:0] ex [5];
    @(negedge clk);
    bus.addr_m = v.addr; bus.write_m = v.we; bus.out_m = v.data;
    scr_rd_addr = v.sa; bus.kbd_valid = v.kv; bus.kbd_code = v.kc;
    ex[0] = v.ei; ex[1] = v.es; ex[2] = v.ec; ex[3] = v.er; ex[4] = v.ee;
    for (int k = 0; k < 5; k++)
      if (v.chk[k]) sb.push_back('{cyc + 1, k, ex[k], $sformatf("%s.%0d", v.name, k)});
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() > 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d expectations never reached, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // RAM latency, read-first, range ends
    vecs.push_back(mk("ram_wr",     16'h0010, 1, 16'h1234, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0));
    vecs.push_back(mk("ram_rd",     16'h0010, 0, 16'h0,    0, 0, 0, 5'b00001, 16'h1234, 0, 0, 0, 0));
    vecs.push_back(mk("ram_rdw",    16'h0010, 1, 16'hBEEF, 0, 0, 0, 5'b00001, 16'h1234, 0, 0, 0, 0));
    vecs.push_back(mk("ram_rd2",    16'h0010, 1, 16'h1234, 0, 0, 0, 5'b00001, 16'hBEEF, 0, 0, 0, 0));
    vecs.push_back(mk("ram_top_wr", 16'h3FFF, 1, 16'hA5A5, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0));
    vecs.push_back(mk("ram_top_rd", 16'h3FFF, 0, 16'h0,    0, 0, 0, 5'b00001, 16'hA5A5, 0, 0, 0, 0));
    vecs.push_back(mk("ram_0_wr",   16'h0000, 1, 16'h0001, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0));
    vecs.push_back(mk("ram_0_rd",   16'h0000, 0, 16'h0,    0, 0, 0, 5'b00001, 16'h0001, 0, 0, 0, 0));
    // Screen: core port and scan-out port
    vecs.push_back(mk("scr_wr",     16'h4005, 1, 16'h00FF, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0));
    vecs.push_back(mk("scr_rd",     16'h4005, 0, 16'h0,    5, 0, 0, 5'b00011, 16'h00FF, 16'h00FF, 0, 0, 0));
    vecs.push_back(mk("scr_top_wr", 16'h5FFF, 1, 16'h7E57, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0));
    vecs.push_back(mk("scr_top_rd", 16'h5FFF, 0, 16'h0, 13'h1FFF, 0, 0, 5'b00011, 16'h7E57, 16'h7E57, 0, 0, 0));
    vecs.push_back(mk("scan_w1",    16'h4006, 1, 16'h1111, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0));
    vecs.push_back(mk("scan_coll",  16'h4006, 1, 16'h2222, 6, 0, 0, 5'b00010, 0, 16'h1111, 0, 0, 0));
    vecs.push_back(mk("scan_new",   16'h0000, 0, 16'h0,    6, 0, 0, 5'b00010, 0, 16'h2222, 0, 0, 0));
    // Key FIFO fill, hold-off, non-destructive read, pops, underflow
    vecs.push_back(mk("kbd_p1",  16'h0000, 0, 0, 0, 1, 16'h41, 5'b01100, 0, 0, 1, 1, 0));
    vecs.push_back(mk("kbd_p2",  16'h0000, 0, 0, 0, 1, 16'h42, 5'b00100, 0, 0, 2, 0, 0));
    vecs.push_back(mk("kbd_p3",  16'h0000, 0, 0, 0, 1, 16'h43, 5'b00100, 0, 0, 3, 0, 0));
    vecs.push_back(mk("kbd_p4",  16'h0000, 0, 0, 0, 1, 16'h44, 5'b01100, 0, 0, 4, 0, 0));
    vecs.push_back(mk("kbd_hold1", 16'h0000, 0, 0, 0, 1, 16'h45, 5'b01100, 0, 0, 4, 0, 0));
    vecs.push_back(mk("kbd_hold2", 16'h0000, 0, 0, 0, 1, 16'h45, 5'b00100, 0, 0, 4, 0, 0));
    vecs.push_back(mk("kbd_rd1", 16'h6000, 0, 0, 0, 1, 16'h45, 5'b00101, 16'h41, 0, 4, 0, 0));
    vecs.push_back(mk("kbd_rd2", 16'h6000, 0, 0, 0, 1, 16'h45, 5'b00101, 16'h41, 0, 4, 0, 0));
    vecs.push_back(mk("kbd_pop", 16'h6000, 1, 16'hFFFF, 0, 1, 16'h45, 5'b01101, 16'h41, 0, 3, 1, 0));
    vecs.push_back(mk("kbd_unblk", 16'h6000, 0, 0, 0, 1, 16'h45, 5'b01101, 16'h42, 0, 4, 0, 0));
    vecs.push_back(mk("kbd_d1",  16'h6000, 1, 0, 0, 0, 0, 5'b00101, 16'h42, 0, 3, 0, 0));
    vecs.push_back(mk("kbd_d2",  16'h6000, 1, 0, 0, 0, 0, 5'b00101, 16'h43, 0, 2, 0, 0));
    vecs.push_back(mk("kbd_d3",  16'h6000, 1, 0, 0, 0, 0, 5'b00101, 16'h44, 0, 1, 0, 0));
    vecs.push_back(mk("kbd_d4",  16'h6000, 1, 0, 0, 0, 0, 5'b00101, 16'h45, 0, 0, 0, 0));
    vecs.push_back(mk("kbd_uflow", 16'h6000, 1, 0, 0, 0, 0, 5'b01101, 16'h0, 0, 0, 1, 0));
    vecs.push_back(mk("kbd_empty", 16'h6000, 0, 0, 0, 0, 0, 5'b00101, 16'h0, 0, 0, 0, 0));
    vecs.push_back(mk("kbd_zero",  16'h6000, 0, 0, 0, 1, 16'h0, 5'b01101, 16'h0, 0, 0, 1, 0));
    // Simultaneous push and pop
    vecs.push_back(mk("sp_p1",   16'h0000, 0, 0, 0, 1, 16'h41, 5'b00100, 0, 0, 1, 0, 0));
    vecs.push_back(mk("sp_p2",   16'h0000, 0, 0, 0, 1, 16'h42, 5'b00100, 0, 0, 2, 0, 0));
    vecs.push_back(mk("sp_both", 16'h6000, 1, 0, 0, 1, 16'h43, 5'b00101, 16'h41, 0, 2, 0, 0));
    vecs.push_back(mk("sp_head", 16'h6000, 0, 0, 0, 0, 0, 5'b00101, 16'h42, 0, 2, 0, 0));
    vecs.push_back(mk("sp_pop",  16'h6000, 1, 0, 0, 0, 0, 5'b00101, 16'h42, 0, 1, 0, 0));
    vecs.push_back(mk("sp_next", 16'h6000, 0, 0, 0, 0, 0, 5'b00101, 16'h43, 0, 1, 0, 0));
    vecs.push_back(mk("sp_p3",   16'h0000, 0, 0, 0, 1, 16'h50, 5'b00100, 0, 0, 2, 0, 0));
    vecs.push_back(mk("sp_p4",   16'h0000, 0, 0, 0, 1, 16'h51, 5'b00100, 0, 0, 3, 0, 0));
    // Unmapped decode, sticky error, dropped writes
    vecs.push_back(mk("un_pre",  16'h5FFF, 0, 0, 0, 0, 0, 5'b10001, 16'h7E57, 0, 0, 0, 0));
    vecs.push_back(mk("un_rd",   16'h6001, 0, 0, 0, 0, 0, 5'b10001, 16'h0, 0, 0, 0, 1));
    vecs.push_back(mk("un_wr",   16'h7FFF, 1, 16'hDEAD, 0, 0, 0, 5'b10001, 16'h0, 0, 0, 0, 1));
    vecs.push_back(mk("un_wr2",  16'hFFFF, 1, 16'hDEAD, 0, 0, 0, 5'b10001, 16'h0, 0, 0, 0, 1));
    vecs.push_back(mk("un_ram",  16'h3FFF, 0, 0, 0, 0, 0, 5'b10001, 16'hA5A5, 0, 0, 0, 1));
    vecs.push_back(mk("un_scr",  16'h5FFF, 0, 0, 0, 0, 0, 5'b10001, 16'h7E57, 0, 0, 0, 1));
    vecs.push_back(mk("pre_rst", 16'h0010, 0, 0, 0, 0, 0, 5'b10101, 16'h1234, 0, 3, 0, 1));

    bus.addr_m = 16'h0; bus.write_m = 1'b0; bus.out_m = 16'h0;
    bus.kbd_valid = 1'b0; bus.kbd_code = 16'h0; scr_rd_addr = '0;
    #1 xrst = 1'b1;
    #1;
    check("reset_in_m", bus.in_m, 16'h0);
    check("reset_scr", scr_rd_data, 16'h0);
    check("reset_count", {13'h0, kbd_count}, 16'h0);
    check("reset_ready", {15'h0, bus.kbd_ready}, 16'h1);
    check("reset_err", {15'h0, err_unmapped}, 16'h0);
    @(negedge clk);
    @(negedge clk);
    xrst = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      drive(vecs[i]);
    drain();

    // Async reset mid-cycle with a pending push that must be lost
    @(posedge clk);
    #2;
    xrst = 1'b1;
    bus.kbd_valid = 1'b1;
    bus.kbd_code = 16'h77;
    #1;
    check("arst_in_m", bus.in_m, 16'h0);
    check("arst_count", {13'h0, kbd_count}, 16'h0);
    check("arst_ready", {15'h0, bus.kbd_ready}, 16'h1);
    check("arst_err", {15'h0, err_unmapped}, 16'h0);
    @(posedge clk);
    @(negedge clk);
    bus.kbd_valid = 1'b0;
    xrst = 1'b0;
    drive(mk("post_ram", 16'h0010, 0, 0, 0, 0, 0, 5'b10101, 16'h1234, 0, 0, 0, 0));
    drive(mk("post_kbd", 16'h6000, 0, 0, 0, 0, 0, 5'b01101, 16'h0, 0, 0, 1, 0));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
